// File: rtl/pci_arbiter.sv
// Four-master PCI bus arbiter: round-robin grant from IDLE, grant revocation on
// timeout or withdrawal, and early grant removal while another master waits.
module pci_arbiter #(
   parameter int GNT_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_n,
   input  logic       frame,
   input  logic       IRDY,
   output logic [3:0] gnt_n,
   output logic [1:0] owner,
   output logic       owner_valid,
   output logic       grant_timeout
);

   localparam int CW = $clog2(GNT_TIMEOUT);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_e;

   state_e        state_q, state_d;
   logic [3:0]    gntN_q, gntN_d;
   logic [1:0]    owner_q, owner_d;
   logic          ownerValid_q, ownerValid_d;
   logic          grantTimeout_q, grantTimeout_d;
   logic [CW-1:0] waitCnt_q, waitCnt_d;
   logic [1:0]    last_q, last_d;

   logic          busIdle;
   logic          winnerFound;
   logic [1:0]    winner;
   logic [3:0]    grantMask;
   logic          othersReq;

   assign busIdle   = frame && IRDY;
   assign grantMask = ~(4'b0001 << last_q);
   assign othersReq = ((~req_n) & grantMask) != 4'b0000;

   // Round-robin search starting just after the most recent winner; the
   // previous winner itself is tried last.
   always_comb begin
      logic [1:0] idx;
      winner      = last_q;
      winnerFound = 1'b0;
      idx         = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!winnerFound && !req_n[idx]) begin
            winner      = idx;
            winnerFound = 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      gntN_d         = gntN_q;
      owner_d        = owner_q;
      ownerValid_d   = ownerValid_q;
      grantTimeout_d = 1'b0;
      waitCnt_d      = waitCnt_q;
      last_d         = last_q;
      unique case (state_q)
         IDLE: begin
            gntN_d       = 4'hF;
            ownerValid_d = 1'b0;
            if (busIdle && winnerFound) begin
               state_d   = GRANT;
               last_d    = winner;
               waitCnt_d = '0;
               gntN_d    = ~(4'b0001 << winner);
            end
         end
         GRANT: begin
            // last_q holds the granted index for the whole GRANT/BUSY episode.
            if (!frame) begin
               state_d      = BUSY;
               owner_d      = last_q;
               ownerValid_d = 1'b1;
               gntN_d       = othersReq ? 4'hF : grantMask;
            end else if (req_n[last_q]) begin
               state_d = IDLE;
               gntN_d  = 4'hF;
            end else if (waitCnt_q == CW'(GNT_TIMEOUT - 1)) begin
               state_d        = IDLE;
               gntN_d         = 4'hF;
               grantTimeout_d = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
         end
         BUSY: begin
            if (busIdle) begin
               state_d      = IDLE;
               gntN_d       = 4'hF;
               ownerValid_d = 1'b0;
            end else begin
               gntN_d = othersReq ? 4'hF : grantMask;
            end
         end
         default: begin
            state_d = IDLE;
            gntN_d  = 4'hF;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         gntN_q         <= 4'hF;
         owner_q        <= 2'd0;
         ownerValid_q   <= 1'b0;
         grantTimeout_q <= 1'b0;
         waitCnt_q      <= '0;
         last_q         <= 2'd3;
      end else begin
         state_q        <= state_d;
         gntN_q         <= gntN_d;
         owner_q        <= owner_d;
         ownerValid_q   <= ownerValid_d;
         grantTimeout_q <= grantTimeout_d;
         waitCnt_q      <= waitCnt_d;
         last_q         <= last_d;
      end
   end

   assign gnt_n         = gntN_q;
   assign owner         = owner_q;
   assign owner_valid   = ownerValid_q;
   assign grant_timeout = grantTimeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Bench for pci_arbiter: directed bus scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural arbiter model.
module tb_pci_arbiter;

   localparam int GNT_TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_n;
   logic       frame;
   logic       IRDY;
   logic [3:0] gnt_n;
   logic [1:0] owner;
   logic       owner_valid;
   logic       grant_timeout;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEnable = 1'b0;

   // Model state: mode 0 = no grant, 1 = granted awaiting FRAME, 2 = transaction.
   int         mMode    = 0;
   int         mLast    = 3;
   int         mWait    = 0;
   int         mOwner   = 0;
   bit         mValid   = 1'b0;
   bit         mTimeout = 1'b0;
   logic [3:0] mGnt     = 4'hF;

   pci_arbiter #(.GNT_TIMEOUT(GNT_TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .req_n(req_n),
      .frame(frame),
      .IRDY(IRDY),
      .gnt_n(gnt_n),
      .owner(owner),
      .owner_valid(owner_valid),
      .grant_timeout(grant_timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic expectOut(input string tag, input logic [3:0] g, input logic [1:0] o, input logic v, input logic t);
      checkOutput({tag, ".gnt_n"}, gnt_n, g);
      checkOutput({tag, ".owner"}, {2'b00, owner}, {2'b00, o});
      checkOutput({tag, ".owner_valid"}, {3'b000, owner_valid}, {3'b000, v});
      checkOutput({tag, ".grant_timeout"}, {3'b000, grant_timeout}, {3'b000, t});
   endtask

   // Inputs change 1 time unit after a rising edge; returns 1 unit after the next one.
   task automatic applyStimulus(input logic [3:0] r, input logic f, input logic ir);
      req_n = r;
      frame = f;
      IRDY  = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Grant pattern for the current owner while a transaction runs: withdrawn as
   // soon as anybody else is asking for the bus.
   function automatic logic [3:0] busGrant(input int who);
      int waiting = 0;
      for (int m = 0; m < 4; m++)
         if (m != who && req_n[m] == 1'b0) waiting++;
      return (waiting > 0) ? 4'hF : (4'hF ^ (4'b0001 << who));
   endfunction

   task automatic updateModel();
      int pick;
      bit idleBus;
      mTimeout = 1'b0;
      if (rst) begin
         mMode  = 0;
         mLast  = 3;
         mWait  = 0;
         mOwner = 0;
         mValid = 1'b0;
         mGnt   = 4'hF;
         return;
      end
      idleBus = frame && IRDY;
      case (mMode)
         0: begin
            mGnt   = 4'hF;
            mValid = 1'b0;
            pick   = -1;
            for (int k = 1; k <= 4; k++)
               if (pick < 0 && req_n[(mLast + k) % 4] == 1'b0) pick = (mLast + k) % 4;
            if (idleBus && pick >= 0) begin
               mMode = 1;
               mLast = pick;
               mWait = 0;
               mGnt  = 4'hF ^ (4'b0001 << pick);
            end
         end
         1: begin
            mWait++;
            if (!frame) begin
               mMode  = 2;
               mOwner = mLast;
               mValid = 1'b1;
               mGnt   = busGrant(mOwner);
            end else if (req_n[mLast]) begin
               mMode = 0;
               mGnt  = 4'hF;
            end else if (mWait == GNT_TIMEOUT) begin
               mMode    = 0;
               mGnt     = 4'hF;
               mTimeout = 1'b1;
            end
         end
         default: begin
            if (idleBus) begin
               mMode  = 0;
               mGnt   = 4'hF;
               mValid = 1'b0;
            end else begin
               mGnt = busGrant(mOwner);
            end
         end
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         updateModel();
      end
   end

   // Outputs are registered, so the falling edge sees them settled.
   always @(negedge clk) begin
      if (checkEnable) begin
         checkOutput("model.gnt_n", gnt_n, mGnt);
         checkOutput("model.owner", {2'b00, owner}, 4'(mOwner));
         checkOutput("model.owner_valid", {3'b000, owner_valid}, {3'b000, mValid});
         checkOutput("model.grant_timeout", {3'b000, grant_timeout}, {3'b000, mTimeout});
         checkOutput("oneGrantMax", 4'($countones(~gnt_n) <= 1), 4'd1);
      end
   end

   initial begin
      rst   = 1'b1;
      req_n = 4'hF;
      frame = 1'b1;
      IRDY  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      expectOut("reset", 4'hF, 2'd0, 1'b0, 1'b0);
      rst         = 1'b0;
      checkEnable = 1'b1;

      $display("[TB] single master");
      applyStimulus(4'b1110, 1'b1, 1'b1);
      expectOut("single.grant", 4'b1110, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b1110, 1'b0, 1'b1);
      expectOut("single.busy", 4'b1110, 2'd0, 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      expectOut("single.idle", 4'hF, 2'd0, 1'b0, 1'b0);

      $display("[TB] round robin");
      pulseReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0000, 1'b1, 1'b1);
         checkOutput("rr.grant", gnt_n, 4'hF ^ (4'b0001 << (i % 4)));
         applyStimulus(4'b0000, 1'b0, 1'b0);
         expectOut("rr.busy", 4'hF, 2'(i % 4), 1'b1, 1'b0);
         applyStimulus(4'b0000, 1'b1, 1'b1);
         expectOut("rr.idle", 4'hF, 2'(i % 4), 1'b0, 1'b0);
      end

      $display("[TB] timeout");
      applyStimulus(4'b1101, 1'b1, 1'b1);
      checkOutput("to.grant", gnt_n, 4'b1101);
      for (int c = 2; c <= GNT_TIMEOUT; c++) begin
         applyStimulus(4'b1101, 1'b1, 1'b1);
         checkOutput("to.hold", gnt_n, 4'b1101);
      end
      applyStimulus(4'b1101, 1'b1, 1'b1);
      expectOut("to.revoke", 4'hF, 2'd0, 1'b0, 1'b1);
      applyStimulus(4'b1100, 1'b1, 1'b1);
      expectOut("to.next", 4'b1110, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      expectOut("to.withdraw", 4'hF, 2'd0, 1'b0, 1'b0);

      $display("[TB] preemption");
      applyStimulus(4'b1110, 1'b1, 1'b1);
      checkOutput("pre.grant", gnt_n, 4'b1110);
      applyStimulus(4'b1110, 1'b0, 1'b1);
      expectOut("pre.busy", 4'b1110, 2'd0, 1'b1, 1'b0);
      applyStimulus(4'b0110, 1'b0, 1'b0);
      expectOut("pre.remove", 4'hF, 2'd0, 1'b1, 1'b0);
      applyStimulus(4'b0110, 1'b0, 1'b1);
      expectOut("pre.hold", 4'hF, 2'd0, 1'b1, 1'b0);
      applyStimulus(4'b0110, 1'b1, 1'b1);
      expectOut("pre.idle", 4'hF, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b0110, 1'b1, 1'b1);
      checkOutput("pre.next", gnt_n, 4'b0111);
      applyStimulus(4'b1111, 1'b1, 1'b1);

      $display("[TB] withdrawal precedence");
      applyStimulus(4'b1101, 1'b1, 1'b1);
      checkOutput("wd.grant", gnt_n, 4'b1101);
      applyStimulus(4'b1111, 1'b0, 1'b1);
      expectOut("wd.frameWins", 4'b1101, 2'd1, 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b1101, 1'b1, 1'b1);
      checkOutput("wd.regrant", gnt_n, 4'b1101);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      expectOut("wd.idle", 4'hF, 2'd1, 1'b0, 1'b0);

      $display("[TB] reset mid transaction");
      applyStimulus(4'b1110, 1'b1, 1'b1);
      applyStimulus(4'b1110, 1'b0, 1'b1);
      expectOut("rb.busy", 4'b1110, 2'd0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      expectOut("rb.async", 4'hF, 2'd0, 1'b0, 1'b0);
      req_n = 4'b0000;
      frame = 1'b1;
      IRDY  = 1'b1;
      @(posedge clk);
      #1;
      expectOut("rb.held", 4'hF, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("rb.first", gnt_n, 4'b1110);
      applyStimulus(4'b1111, 1'b1, 1'b1);

      $display("[TB] random traffic");
      for (int n = 0; n < 4000; n++) begin
         logic [3:0] r;
         logic       f;
         logic       ir;
         r  = req_n;
         f  = frame;
         ir = IRDY;
         if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) f = ~f;
         if ($urandom_range(0, 2) == 0) ir = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 499) == 0) pulseReset();
         applyStimulus(r, f, ir);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
